unidade_inferencia_regras: RTL and testbench
============================================

# unidade_inferencia_regras

Rule-inference responder for the type-2 (interval) fuzzy processor. It sits downstream of the rule-sequencing control unit and consumes its rule strobe (`clk_int`), rule index (`Sequencia_regras`) and clear (`Reset_Inf`). For each strobed rule it computes upper and lower firing strengths from the interval membership grades and max-accumulates them per consequent. At end of sequence it delivers the consequent strength vectors over a valid/ready handshake.

## Interface
- `W`, 8: membership-grade / strength width
- `N_REGRAS`, 9: number of valid rules (≤16)
- `N_CONS`, 3: number of consequent sets
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `Reset_Inf` in 1: synchronous clear of accumulators/flags, highest priority after `rst`
- `clk_int` in 1: rule strobe, level from controller, rising edge detected on `clk`
- `Sequencia_regras` in 4: rule index, sampled on strobe edge
- `EN_REGRAS` in 1: sequence enable; falling edge = end of sequence
- `mu_sup_A`, `mu_inf_A`, `mu_sup_B`, `mu_inf_B` in 3*W: upper/lower grades, 3 sets per input, set k at [k*W +: W]
- `F_sup`, `F_inf` out N_CONS*W: accumulated upper/lower strengths per consequent
- `saida_valida` out 1: result valid; `saida_pronta` in 1: downstream ready
- `ocupado` out 1: high in CALC/ACUM/ENTREGA
- `erro_regra` out 1: sticky, index ≥ N_REGRAS seen
- `erro_sobreposicao` out 1: sticky, strobe dropped while busy

## Operation
- States: ESPERA, CALC, ACUM, ENTREGA.
- ESPERA: strobe edge (`clk_int`=1, previous sample 0) captures index. Index ≥ N_REGRAS → set `erro_regra`, stay ESPERA. Otherwise table lookup `(ia, ib, cons)` → CALC.
- CALC: `s_sup = min(mu_sup_A[ia], mu_sup_B[ib])`, `s_inf = min(mu_inf_A[ia], mu_inf_B[ib])`, registered → ACUM.
- ACUM: `F_sup[cons] = max(F_sup[cons], s_sup)`, same for inf → ESPERA, or ENTREGA if end pending.
- `EN_REGRAS` falling edge: in ESPERA → ENTREGA next cycle; in CALC/ACUM → set end-pending, finish rule, then ENTREGA.
- ENTREGA: `saida_valida`=1, `F_*` frozen. Transfer on `saida_valida && saida_pronta` → clear accumulators, ESPERA.
- Strobe edge in CALC/ACUM/ENTREGA: discarded, `erro_sobreposicao`=1.
- `Reset_Inf`=1 in any state: accumulators 0, flags 0, end-pending 0, in-flight rule aborted, `saida_valida`=0, → ESPERA. Same-cycle strobe discarded without error.
- No lower ≤ upper check; sup/inf paths are independent. Max cannot overflow; no saturation logic.

## Timing
- Reset (`rst`): state ESPERA, all `F_*`=0, `saida_valida`/`ocupado`/`erro_*`=0, edge registers 0.
- Strobe sampled at edge k → CALC at k+1 → accumulator updated at edge k+2 → ESPERA. Minimum strobe spacing 3 cycles.
- Grades must be stable from edge k to k+1.
- End of sequence in ESPERA: `saida_valida` high 2 edges after `EN_REGRAS` sampled low (edge detect + transition).
- `saida_valida` deasserts on the edge after handshake; `F_*` read 0 thereafter.

## Configuration
- `FUZZY_PROD_TNORM_EN` defined: t-norm is product, `s = (a*b) >> W` (top W bits of 2W product), same CALC latency.
- Undefined: t-norm is min. Accumulation is max in both builds.

## Structure
- Package `pkg_fuzzy_inferencia`: `W`/`N_REGRAS`/`N_CONS` defaults, state enum, rule table constant (ia = r/3, ib = r%3, cons = {0,0,1,0,1,2,1,2,2} for r=0..8).
- Sub-module `tnorm_intervalo`: combinational sup/inf t-norm pair, macro-selected min/product.

## Test plan
- `Reset_Inf`, A1=200/120, B1=150/100, strobe idx 4 → after 2 edges `F_sup[1]`=150, `F_inf[1]`=100, others 0. `EN_REGRAS` falls → `saida_valida`=1.
- Idx 2 (80/40 → cons 1) then idx 4 (150/100), and reverse order → both `F_sup[1]`=150, `F_inf[1]`=100.
- Strobes 2 cycles apart → second dropped, `erro_sobreposicao`=1. Idx 12 → `erro_regra`=1, accumulators unchanged.
- ENTREGA, `saida_pronta`=0 for 5 cycles → valid held, `F_*` stable. Ready=1 → valid 0 next edge, `F_*`=0.
- `Reset_Inf` during CALC → rule not accumulated, state ESPERA. `rst` mid-ENTREGA → all outputs 0.
- With `FUZZY_PROD_TNORM_EN`: 200×150 → `F_sup`=117, 120×100 → `F_inf`=46.

Source files
------------

// File: rtl/unidade_inferencia_regras_pkg.sv
// Shared defaults, FSM states and the rule table for the interval type-2 inference unit.
package pkg_fuzzy_inferencia;

   localparam int W_PADRAO        = 8;
   localparam int N_REGRAS_PADRAO = 9;
   localparam int N_CONS_PADRAO   = 3;

   typedef enum logic [1:0] {
      ESPERA  = 2'd0,
      CALC    = 2'd1,
      ACUM    = 2'd2,
      ENTREGA = 2'd3
   } estado_t;

   typedef struct packed {
      logic [1:0] ia;
      logic [1:0] ib;
      logic [1:0] cons;
   } regra_t;

   // Rule r pairs set r/3 of input A with set r%3 of input B.
   localparam regra_t TABELA_REGRAS [0:8] = '{
      '{ia: 2'd0, ib: 2'd0, cons: 2'd0},
      '{ia: 2'd0, ib: 2'd1, cons: 2'd0},
      '{ia: 2'd0, ib: 2'd2, cons: 2'd1},
      '{ia: 2'd1, ib: 2'd0, cons: 2'd0},
      '{ia: 2'd1, ib: 2'd1, cons: 2'd1},
      '{ia: 2'd1, ib: 2'd2, cons: 2'd2},
      '{ia: 2'd2, ib: 2'd0, cons: 2'd1},
      '{ia: 2'd2, ib: 2'd1, cons: 2'd2},
      '{ia: 2'd2, ib: 2'd2, cons: 2'd2}
   };

   function automatic regra_t consulta_regra(input logic [3:0] r);
      regra_t t;
      if (r <= 4'd8) t = TABELA_REGRAS[r];
      else           t = '{ia: 2'd0, ib: 2'd0, cons: 2'd0};
      return t;
   endfunction

endpackage

// File: rtl/unidade_inferencia_regras_tnorm.sv
// Combinational sup/inf t-norm pair. Min by default; product (top W bits)
// when FUZZY_PROD_TNORM_EN is defined.
module tnorm_intervalo
   import pkg_fuzzy_inferencia::*;
#(
   parameter int W = W_PADRAO
) (
   input  logic [W-1:0] a_sup,
   input  logic [W-1:0] b_sup,
   input  logic [W-1:0] a_inf,
   input  logic [W-1:0] b_inf,
   output logic [W-1:0] s_sup,
   output logic [W-1:0] s_inf
);

`ifdef FUZZY_PROD_TNORM_EN
   assign s_sup = W'(({{W{1'b0}}, a_sup} * {{W{1'b0}}, b_sup}) >> W);
   assign s_inf = W'(({{W{1'b0}}, a_inf} * {{W{1'b0}}, b_inf}) >> W);
`else
   assign s_sup = (a_sup < b_sup) ? a_sup : b_sup;
   assign s_inf = (a_inf < b_inf) ? a_inf : b_inf;
`endif

endmodule

// File: rtl/unidade_inferencia_regras.sv
// Rule-inference responder: per strobed rule computes interval firing strengths and
// max-accumulates them per consequent; FUZZY_PROD_TNORM_EN selects the product t-norm.
module unidade_inferencia_regras
   import pkg_fuzzy_inferencia::*;
#(
   parameter int W        = W_PADRAO,
   parameter int N_REGRAS = N_REGRAS_PADRAO,
   parameter int N_CONS   = N_CONS_PADRAO
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                Reset_Inf,
   input  logic                clk_int,
   input  logic [3:0]          Sequencia_regras,
   input  logic                EN_REGRAS,
   input  logic [3*W-1:0]      mu_sup_A,
   input  logic [3*W-1:0]      mu_inf_A,
   input  logic [3*W-1:0]      mu_sup_B,
   input  logic [3*W-1:0]      mu_inf_B,
   output logic [N_CONS*W-1:0] F_sup,
   output logic [N_CONS*W-1:0] F_inf,
   output logic                saida_valida,
   input  logic                saida_pronta,
   output logic                ocupado,
   output logic                erro_regra,
   output logic                erro_sobreposicao
);

   estado_t      estado, prox_estado;
   regra_t       regra;
   logic         clk_int_ant, en_ant, fim_pendente;
   logic         borda_regra, fim_seq, indice_valido, transferencia;
   logic [W-1:0] a_sup, b_sup, a_inf, b_inf, t_sup, t_inf;
   logic [W-1:0] grau_sup, grau_inf;
   logic [W-1:0] acc_sup [N_CONS];
   logic [W-1:0] acc_inf [N_CONS];

   function automatic logic [W-1:0] sel_grau(input logic [3*W-1:0] v, input logic [1:0] k);
      case (k)
         2'd0:    return v[0 +: W];
         2'd1:    return v[W +: W];
         2'd2:    return v[2*W +: W];
         default: return {W{1'b0}};
      endcase
   endfunction

   function automatic logic [W-1:0] maximo(input logic [W-1:0] x, input logic [W-1:0] y);
      return (x > y) ? x : y;
   endfunction

   assign borda_regra   = clk_int & ~clk_int_ant;
   assign fim_seq       = en_ant & ~EN_REGRAS;
   assign indice_valido = ({28'd0, Sequencia_regras} < 32'(N_REGRAS));
   // saida_valida is only ever high while in ENTREGA
   assign transferencia = saida_valida & saida_pronta;

   assign a_sup = sel_grau(mu_sup_A, regra.ia);
   assign b_sup = sel_grau(mu_sup_B, regra.ib);
   assign a_inf = sel_grau(mu_inf_A, regra.ia);
   assign b_inf = sel_grau(mu_inf_B, regra.ib);

   tnorm_intervalo #(.W(W)) u_tnorm (
      .a_sup (a_sup),
      .b_sup (b_sup),
      .a_inf (a_inf),
      .b_inf (b_inf),
      .s_sup (t_sup),
      .s_inf (t_inf)
   );

   // Next-state logic; the soft clear overrides everything.
   always_comb begin
      prox_estado = estado;
      if (Reset_Inf) begin
         prox_estado = ESPERA;
      end else begin
         case (estado)
            ESPERA: begin
               if (borda_regra && indice_valido) prox_estado = CALC;
               else if (fim_seq)                 prox_estado = ENTREGA;
               else                              prox_estado = ESPERA;
            end
            CALC:    prox_estado = ACUM;
            ACUM: begin
               if (fim_pendente || fim_seq) prox_estado = ENTREGA;
               else                         prox_estado = ESPERA;
            end
            ENTREGA: begin
               if (transferencia) prox_estado = ESPERA;
               else               prox_estado = ENTREGA;
            end
            default: prox_estado = ESPERA;
         endcase
      end
   end

   // State, edge detectors, captured rule, strength pipeline and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado            <= ESPERA;
         clk_int_ant       <= 1'b0;
         en_ant            <= 1'b0;
         fim_pendente      <= 1'b0;
         regra             <= '{ia: 2'd0, ib: 2'd0, cons: 2'd0};
         grau_sup          <= {W{1'b0}};
         grau_inf          <= {W{1'b0}};
         saida_valida      <= 1'b0;
         ocupado           <= 1'b0;
         erro_regra        <= 1'b0;
         erro_sobreposicao <= 1'b0;
      end else begin
         clk_int_ant <= clk_int;
         en_ant      <= EN_REGRAS;
         estado      <= prox_estado;
         ocupado     <= (prox_estado != ESPERA);
         if (Reset_Inf) begin
            fim_pendente      <= 1'b0;
            saida_valida      <= 1'b0;
            erro_regra        <= 1'b0;
            erro_sobreposicao <= 1'b0;
         end else begin
            // Valid rises one edge after entering ENTREGA and drops on the transfer edge.
            saida_valida <= (estado == ENTREGA) && !transferencia;
            if (estado == ESPERA && borda_regra && indice_valido)
               regra <= consulta_regra(Sequencia_regras);
            if (estado == ESPERA && borda_regra && !indice_valido)
               erro_regra <= 1'b1;
            if (estado != ESPERA && borda_regra)
               erro_sobreposicao <= 1'b1;
            if (prox_estado == ENTREGA)
               fim_pendente <= 1'b0;
            else if (fim_seq && (prox_estado == CALC || prox_estado == ACUM))
               fim_pendente <= 1'b1;
            if (estado == CALC) begin
               grau_sup <= t_sup;
               grau_inf <= t_inf;
            end
         end
      end
   end

   // Per-consequent max accumulators, cleared on soft clear or delivery.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < N_CONS; c++) begin
            acc_sup[c] <= {W{1'b0}};
            acc_inf[c] <= {W{1'b0}};
         end
      end else if (Reset_Inf || transferencia) begin
         for (int c = 0; c < N_CONS; c++) begin
            acc_sup[c] <= {W{1'b0}};
            acc_inf[c] <= {W{1'b0}};
         end
      end else if (estado == ACUM) begin
         for (int c = 0; c < N_CONS; c++) begin
            if (regra.cons == 2'(c)) begin
               acc_sup[c] <= maximo(acc_sup[c], grau_sup);
               acc_inf[c] <= maximo(acc_inf[c], grau_inf);
            end
         end
      end
   end

   for (genvar c = 0; c < N_CONS; c++) begin : g_saida
      assign F_sup[c*W +: W] = acc_sup[c];
      assign F_inf[c*W +: W] = acc_inf[c];
   end

endmodule

// File: tb/tb_unidade_inferencia_regras.sv
// Self-checking bench for unidade_inferencia_regras: vector table, corner sequences
// and randomized rule sequences against an arithmetic reference model.
module tb_unidade_inferencia_regras;

   localparam int W  = 8;
   localparam int NC = 3;

   logic          clk = 1'b0;
   logic          rst, Reset_Inf, clk_int, EN_REGRAS, saida_pronta;
   logic [3:0]    Sequencia_regras;
   logic [3*W-1:0] mu_sup_A, mu_inf_A, mu_sup_B, mu_inf_B;
   logic [NC*W-1:0] F_sup, F_inf;
   logic          saida_valida, ocupado, erro_regra, erro_sobreposicao;

   int n_checks = 0;
   int n_fail   = 0;
   int ga_sup[3], ga_inf[3], gb_sup[3], gb_inf[3];
   int m_sup[3], m_inf[3];
   bit m_err;
   int cons_tab[9] = '{0, 0, 1, 0, 1, 2, 1, 2, 2};

   typedef struct {
      logic [3:0] idx;
      int         cons;
      int         s_sup;
      int         s_inf;
   } vetor_t;
   vetor_t tab[8];

   always #5 clk = ~clk;

   unidade_inferencia_regras dut (
      .clk               (clk),
      .rst               (rst),
      .Reset_Inf         (Reset_Inf),
      .clk_int           (clk_int),
      .Sequencia_regras  (Sequencia_regras),
      .EN_REGRAS         (EN_REGRAS),
      .mu_sup_A          (mu_sup_A),
      .mu_inf_A          (mu_inf_A),
      .mu_sup_B          (mu_sup_B),
      .mu_inf_B          (mu_inf_B),
      .F_sup             (F_sup),
      .F_inf             (F_inf),
      .saida_valida      (saida_valida),
      .saida_pronta      (saida_pronta),
      .ocupado           (ocupado),
      .erro_regra        (erro_regra),
      .erro_sobreposicao (erro_sobreposicao)
   );

   function automatic int tn(input int a, input int b);
`ifdef FUZZY_PROD_TNORM_EN
      return (a * b) / 256;
`else
      return (a < b) ? a : b;
`endif
   endfunction

   function automatic logic [23:0] empacota(input int v0, input int v1, input int v2);
      return {v2[7:0], v1[7:0], v0[7:0]};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic verifica_b(input string nome, input logic atual, input logic esperado);
      n_checks++;
      if (atual !== esperado) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b", nome, atual, esperado);
      end
   endtask

   task automatic verifica_v(input string nome, input logic [23:0] atual, input logic [23:0] esperado);
      n_checks++;
      if (atual !== esperado) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nome, atual, esperado);
      end
   endtask

   task automatic aplica_graus;
      mu_sup_A = empacota(ga_sup[0], ga_sup[1], ga_sup[2]);
      mu_inf_A = empacota(ga_inf[0], ga_inf[1], ga_inf[2]);
      mu_sup_B = empacota(gb_sup[0], gb_sup[1], gb_sup[2]);
      mu_inf_B = empacota(gb_inf[0], gb_inf[1], gb_inf[2]);
   endtask

   task automatic limpa_modelo;
      for (int k = 0; k < 3; k++) begin
         m_sup[k] = 0;
         m_inf[k] = 0;
      end
      m_err = 1'b0;
   endtask

   task automatic modelo_regra(input int r);
      if (r >= 9) begin
         m_err = 1'b1;
      end else begin
         int c = cons_tab[r];
         int s = tn(ga_sup[r / 3], gb_sup[r % 3]);
         int i = tn(ga_inf[r / 3], gb_inf[r % 3]);
         if (s > m_sup[c]) m_sup[c] = s;
         if (i > m_inf[c]) m_inf[c] = i;
      end
   endtask

   task automatic confere_modelo(input string nome);
      verifica_v({nome, " F_sup"}, F_sup, empacota(m_sup[0], m_sup[1], m_sup[2]));
      verifica_v({nome, " F_inf"}, F_inf, empacota(m_inf[0], m_inf[1], m_inf[2]));
   endtask

   task automatic pulso_reset_inf;
      Reset_Inf = 1'b1;
      tick;
      Reset_Inf = 1'b0;
      limpa_modelo;
   endtask

   // strobe one rule and wait until its accumulation has landed
   task automatic regra(input int r);
      Sequencia_regras = 4'(r);
      clk_int = 1'b1;
      tick;
      clk_int = 1'b0;
      tick;
      tick;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [23:0] e_sup, e_inf;
      int nr, r, c;

`ifdef FUZZY_PROD_TNORM_EN
      tab[0] = '{4'd4,  1, 117, 46};
      tab[1] = '{4'd2,  1,  31, 10};
      tab[2] = '{4'd0,  0,  18,  3};
      tab[3] = '{4'd8,  2,  35,  8};
      tab[4] = '{4'd5,  2,  78, 32};
      tab[5] = '{4'd12, -1,  0,  0};
      tab[6] = '{4'd9,  -1,  0,  0};
      tab[7] = '{4'd6,  1,  21,  2};
`else
      tab[0] = '{4'd4,  1, 150, 100};
      tab[1] = '{4'd2,  1,  80,  40};
      tab[2] = '{4'd0,  0,  60,  20};
      tab[3] = '{4'd8,  2,  90,  30};
      tab[4] = '{4'd5,  2, 100,  70};
      tab[5] = '{4'd12, -1,  0,   0};
      tab[6] = '{4'd9,  -1,  0,   0};
      tab[7] = '{4'd6,  1,  60,  20};
`endif

      ga_sup = '{80, 200, 90};  ga_inf = '{40, 120, 30};
      gb_sup = '{60, 150, 100}; gb_inf = '{20, 100, 70};
      aplica_graus;
      rst = 1'b1; Reset_Inf = 1'b0; clk_int = 1'b0; EN_REGRAS = 1'b0;
      saida_pronta = 1'b0; Sequencia_regras = 4'd0;
      limpa_modelo;
      tick; tick;
      rst = 1'b0;
      tick;

      verifica_v("reset F_sup", F_sup, 24'd0);
      verifica_v("reset F_inf", F_inf, 24'd0);
      verifica_b("reset saida_valida", saida_valida, 1'b0);
      verifica_b("reset ocupado", ocupado, 1'b0);
      verifica_b("reset erro_regra", erro_regra, 1'b0);
      verifica_b("reset erro_sobreposicao", erro_sobreposicao, 1'b0);

      EN_REGRAS = 1'b1;
      tick;

      for (int i = 0; i < 8; i++) begin
         pulso_reset_inf;
         regra(int'(tab[i].idx));
         e_sup = (tab[i].cons < 0) ? 24'd0 : (24'(tab[i].s_sup) << (8 * tab[i].cons));
         e_inf = (tab[i].cons < 0) ? 24'd0 : (24'(tab[i].s_inf) << (8 * tab[i].cons));
         verifica_v($sformatf("tab%0d F_sup", i), F_sup, e_sup);
         verifica_v($sformatf("tab%0d F_inf", i), F_inf, e_inf);
         verifica_b($sformatf("tab%0d erro_regra", i), erro_regra, tab[i].cons < 0);
      end

      // single rule, end of sequence, back-pressure, transfer
      pulso_reset_inf;
      regra(4); modelo_regra(4);
      EN_REGRAS = 1'b0;
      tick;
      verifica_b("fim valida after 1 edge", saida_valida, 1'b0);
      verifica_b("fim ocupado", ocupado, 1'b1);
      tick;
      verifica_b("fim valida after 2 edges", saida_valida, 1'b1);
      for (int k = 0; k < 5; k++) begin
         tick;
         verifica_b("hold valida", saida_valida, 1'b1);
         confere_modelo("hold");
      end
      saida_pronta = 1'b1;
      tick;
      saida_pronta = 1'b0;
      verifica_b("xfer valida", saida_valida, 1'b0);
      verifica_v("xfer F_sup", F_sup, 24'd0);
      verifica_v("xfer F_inf", F_inf, 24'd0);
      verifica_b("xfer ocupado", ocupado, 1'b0);
      EN_REGRAS = 1'b1;
      tick;

      // order independence of max accumulation
      pulso_reset_inf;
      regra(2); modelo_regra(2);
      regra(4); modelo_regra(4);
      confere_modelo("ordem 2,4");
      pulso_reset_inf;
      regra(4); modelo_regra(4);
      regra(2); modelo_regra(2);
      confere_modelo("ordem 4,2");

      // overlapping strobe two cycles after the first
      pulso_reset_inf;
      Sequencia_regras = 4'd4; clk_int = 1'b1; tick;
      clk_int = 1'b0; tick;
      Sequencia_regras = 4'd0; clk_int = 1'b1; tick;
      clk_int = 1'b0; tick; tick;
      modelo_regra(4);
      verifica_b("sobrepos erro", erro_sobreposicao, 1'b1);
      verifica_b("sobrepos erro_regra", erro_regra, 1'b0);
      confere_modelo("sobrepos");
      regra(12); modelo_regra(12);
      verifica_b("idx12 erro_regra", erro_regra, 1'b1);
      confere_modelo("idx12 inalterado");

      // soft clear while CALC aborts the rule
      pulso_reset_inf;
      Sequencia_regras = 4'd4; clk_int = 1'b1; tick;
      clk_int = 1'b0; Reset_Inf = 1'b1; tick;
      Reset_Inf = 1'b0; tick; tick;
      verifica_v("abort F_sup", F_sup, 24'd0);
      verifica_v("abort F_inf", F_inf, 24'd0);
      verifica_b("abort ocupado", ocupado, 1'b0);
      Reset_Inf = 1'b1; clk_int = 1'b1; tick;
      Reset_Inf = 1'b0; clk_int = 1'b0; tick; tick;
      verifica_v("clr+strobe F_sup", F_sup, 24'd0);
      verifica_b("clr+strobe erro_sobreposicao", erro_sobreposicao, 1'b0);
      verifica_b("clr+strobe ocupado", ocupado, 1'b0);

      // end of sequence while CALC: rule finishes, then delivery
      pulso_reset_inf;
      Sequencia_regras = 4'd5; clk_int = 1'b1; tick;
      clk_int = 1'b0; EN_REGRAS = 1'b0; tick;
      tick;
      modelo_regra(5);
      confere_modelo("pendente");
      verifica_b("pendente ocupado", ocupado, 1'b1);
      tick;
      verifica_b("pendente valida", saida_valida, 1'b1);
      saida_pronta = 1'b1; tick;
      saida_pronta = 1'b0;
      verifica_b("pendente xfer", saida_valida, 1'b0);
      EN_REGRAS = 1'b1; tick;

      // async reset mid-delivery
      pulso_reset_inf;
      regra(4);
      EN_REGRAS = 1'b0;
      tick; tick;
      verifica_b("pre-rst valida", saida_valida, 1'b1);
      #2 rst = 1'b1;
      #1;
      verifica_v("rst F_sup", F_sup, 24'd0);
      verifica_v("rst F_inf", F_inf, 24'd0);
      verifica_b("rst valida", saida_valida, 1'b0);
      verifica_b("rst ocupado", ocupado, 1'b0);
      tick;
      rst = 1'b0; EN_REGRAS = 1'b1;
      tick;

      // randomized rule sequences
      for (int it = 0; it < 40; it++) begin
         pulso_reset_inf;
         for (int k = 0; k < 3; k++) begin
            ga_sup[k] = int'($urandom_range(0, 255));
            ga_inf[k] = int'($urandom_range(0, 255));
            gb_sup[k] = int'($urandom_range(0, 255));
            gb_inf[k] = int'($urandom_range(0, 255));
         end
         aplica_graus;
         nr = int'($urandom_range(1, 6));
         for (int j = 0; j < nr; j++) begin
            r = int'($urandom_range(0, 15));
            regra(r);
            modelo_regra(r);
         end
         EN_REGRAS = 1'b0;
         c = 0;
         while (!saida_valida && c < 10) begin
            tick;
            c++;
         end
         verifica_b($sformatf("rnd%0d valida", it), saida_valida, 1'b1);
         confere_modelo($sformatf("rnd%0d", it));
         verifica_b($sformatf("rnd%0d erro_regra", it), erro_regra, m_err);
         repeat ($urandom_range(0, 3)) tick;
         saida_pronta = 1'b1; tick;
         saida_pronta = 1'b0;
         verifica_b($sformatf("rnd%0d xfer", it), saida_valida, 1'b0);
         verifica_v($sformatf("rnd%0d clr", it), F_sup, 24'd0);
         EN_REGRAS = 1'b1;
         tick;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
